// File: rtl/beta_pkg.sv
// Shared Beta control encodings and the bundled control word handed to the datapath.
package beta_pkg;

    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_JMP = 6'b011011;
    localparam logic [5:0] OP_BEQ = 6'b011100;
    localparam logic [5:0] OP_BNE = 6'b011101;
    localparam logic [5:0] OP_LDR = 6'b011111;

    localparam logic [5:0] ALUFN_ADD    = 6'b000000;
    localparam logic [5:0] ALUFN_PASS_A = 6'b011010;

    localparam int PCSEL_W = 3;
    localparam logic [PCSEL_W-1:0] PCSEL_INC   = 3'd0;
    localparam logic [PCSEL_W-1:0] PCSEL_BR    = 3'd1;
    localparam logic [PCSEL_W-1:0] PCSEL_JMP   = 3'd2;
    localparam logic [PCSEL_W-1:0] PCSEL_ILLOP = 3'd3;
    localparam logic [PCSEL_W-1:0] PCSEL_IRQ   = 3'd4;

    localparam logic [1:0] WDSEL_PC  = 2'd0;
    localparam logic [1:0] WDSEL_ALU = 2'd1;
    localparam logic [1:0] WDSEL_MEM = 2'd2;

    typedef struct packed {
        logic [5:0]         alufn;
        logic               asel;
        logic               bsel;
        logic               moe;
        logic               mwr;
        logic               ra2sel;
        logic               wasel;
        logic               werf;
        logic [PCSEL_W-1:0] pcsel;
        logic [1:0]         wdsel;
        logic               trap;
    } ctl_word_t;

    localparam ctl_word_t CTL_NOP = '0;

    function automatic logic is_legal(input logic [5:0] op);
        logic legal;
        legal = op[5];
        case (op)
            OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR: legal = 1'b1;
            default: ;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/beta_decode.sv
// Combinational Beta opcode decoder; trap words override the instruction decode.
module beta_decode
    import beta_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic       take_irq,
    output ctl_word_t  ctl
);

    logic bne;

    assign bne = (opcode == OP_BNE);

    always_comb begin
        ctl = CTL_NOP;
        if (take_irq || !is_legal(opcode)) begin
            // Trap: save PC+4 into XP; everything that could touch memory stays off.
            ctl.trap  = 1'b1;
            ctl.wasel = 1'b1;
            ctl.werf  = 1'b1;
            ctl.wdsel = WDSEL_PC;
            ctl.pcsel = take_irq ? PCSEL_IRQ : PCSEL_ILLOP;
        end else if (opcode[5]) begin
            ctl.alufn = {2'b10, opcode[3:0]};
            ctl.bsel  = opcode[4];
            ctl.wdsel = WDSEL_ALU;
            ctl.werf  = 1'b1;
        end else begin
            case (opcode)
                OP_LD: begin
                    ctl.alufn = ALUFN_ADD;
                    ctl.bsel  = 1'b1;
                    ctl.moe   = 1'b1;
                    ctl.wdsel = WDSEL_MEM;
                    ctl.werf  = 1'b1;
                end
                OP_ST: begin
                    ctl.alufn  = ALUFN_ADD;
                    ctl.bsel   = 1'b1;
                    ctl.ra2sel = 1'b1;
                    ctl.mwr    = 1'b1;
                end
                OP_JMP: begin
                    ctl.pcsel = PCSEL_JMP;
                    ctl.wdsel = WDSEL_PC;
                    ctl.werf  = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    ctl.pcsel = (z ^ bne) ? PCSEL_BR : PCSEL_INC;
                    ctl.wdsel = WDSEL_PC;
                    ctl.werf  = 1'b1;
                end
                OP_LDR: begin
                    ctl.alufn = ALUFN_PASS_A;
                    ctl.asel  = 1'b1;
                    ctl.moe   = 1'b1;
                    ctl.wdsel = WDSEL_MEM;
                    ctl.werf  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/beta_ctrl_pipe.sv
// Handshaked Beta control unit: one registered control word plus interrupt-pending latch.
//  state | meaning
//  EMPTY | no control word held; outputs forced to the all-zero safe word
//  FULL  | control word held and presented with ctl_valid=1
module beta_ctrl_pipe
    import beta_pkg::*;
#(
    parameter int IW     = 32,
    parameter int PCS_W  = 3,
    parameter bit IRQ_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [IW-1:0]    instruction,
    input  logic             pc_super,
    input  logic             z,
    input  logic             irq,
    input  logic             flush,
    output logic             ctl_valid,
    input  logic             ctl_ready,
    output logic [5:0]       ALUFN,
    output logic             ASEL,
    output logic             BSEL,
    output logic             MOE,
    output logic             MWR,
    output logic             RA2SEL,
    output logic             WASEL,
    output logic             WERF,
    output logic [PCS_W-1:0] PCSEL,
    output logic [1:0]       WDSEL,
    output logic             trap
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t    state;
    ctl_word_t ctl_q;
    ctl_word_t dec_word;
    logic      irq_pend;
    logic      accept;
    logic      take_irq;
    logic [5:0] opcode;
    logic      unused_operand_bits;

    assign opcode              = instruction[IW-1 -: 6];
    assign unused_operand_bits = ^instruction[IW-7:0];

    assign ctl_valid  = (state == S_FULL);
    assign inst_ready = !flush && (!ctl_valid || ctl_ready);
    assign accept     = inst_valid && inst_ready;
    assign take_irq   = IRQ_EN && (irq_pend || irq) && !pc_super;

    beta_decode u_decode (
        .opcode   (opcode),
        .z        (z),
        .take_irq (take_irq),
        .ctl      (dec_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_EMPTY;
            ctl_q    <= CTL_NOP;
            irq_pend <= 1'b0;
        end else begin
            // Clearing on an IRQ accept beats a same-cycle set; a held irq re-arms next cycle.
            irq_pend <= IRQ_EN && !(accept && take_irq) && (irq || irq_pend);
            if (flush) begin
                state <= S_EMPTY;
                ctl_q <= CTL_NOP;
            end else begin
                case (state)
                    S_EMPTY: begin
                        if (accept) begin
                            state <= S_FULL;
                            ctl_q <= dec_word;
                        end
                    end
                    S_FULL: begin
                        if (accept) begin
                            ctl_q <= dec_word;
                        end else if (ctl_ready) begin
                            state <= S_EMPTY;
                            ctl_q <= CTL_NOP;
                        end
                    end
                    default: begin
                        state <= S_EMPTY;
                        ctl_q <= CTL_NOP;
                    end
                endcase
            end
        end
    end

    assign ALUFN  = ctl_q.alufn;
    assign ASEL   = ctl_q.asel;
    assign BSEL   = ctl_q.bsel;
    assign MOE    = ctl_q.moe;
    assign MWR    = ctl_q.mwr;
    assign RA2SEL = ctl_q.ra2sel;
    assign WASEL  = ctl_q.wasel;
    assign WERF   = ctl_q.werf;
    assign PCSEL  = PCS_W'(ctl_q.pcsel);
    assign WDSEL  = ctl_q.wdsel;
    assign trap   = ctl_q.trap;

endmodule
